// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack handshake
// and buffers {instruction, pc+1} pairs for decode behind a valid/ready port.
module if_prefetch_unit #(
  parameter int ADDRESS_LEN     = 12,
  parameter int INSTRUCTION_LEN = 19,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDRESS_LEN-1:0]     redirect_pc,
  input  logic                       id_ready,
  output logic                       if_valid,
  output logic [INSTRUCTION_LEN-1:0] if_instruction,
  output logic [ADDRESS_LEN-1:0]     if_pc_plus1
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t                                 r_state, w_state_nxt;
  logic [ADDRESS_LEN-1:0]                 r_pc, r_addr;
  logic [CW-1:0]                          r_count, w_count_nxt;
  logic [PW-1:0]                          r_rd_ptr, r_wr_ptr;
  logic [DEPTH-1:0][INSTRUCTION_LEN-1:0]  r_mem_ins;
  logic [DEPTH-1:0][ADDRESS_LEN-1:0]      r_mem_pc1;
  logic [ADDRESS_LEN-1:0]                 w_addr_p1, w_issue_addr;
  logic                                   w_push, w_pop, w_issue, w_empty;

  assign w_addr_p1    = r_addr + ADDRESS_LEN'(1);
  assign w_empty      = (r_count == '0);
  assign w_push       = (r_state == S_WAIT) && imem_ack && !redirect_valid;
  assign w_pop        = if_valid && id_ready;
  assign w_count_nxt  = redirect_valid ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  // A back-to-back issue follows the response just accepted, so it uses addr+1.
  assign w_issue_addr = (r_state == S_WAIT) ? w_addr_p1 : r_pc;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!redirect_valid && (r_count < LP_DEPTH)) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_state_nxt = imem_ack ? S_IDLE : S_DROP;
        end else if (imem_ack) begin
          if (w_count_nxt < LP_DEPTH) begin
            w_issue     = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (imem_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= '0;
      r_addr   <= '0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (redirect_valid) r_pc <= redirect_pc;
      else if (w_push)    r_pc <= w_addr_p1;
      if (w_issue) r_addr <= w_issue_addr;
      r_count <= w_count_nxt;
      // Flush by collapsing the read pointer onto the write pointer.
      if (redirect_valid) r_rd_ptr <= r_wr_ptr;
      else if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ins[r_wr_ptr] <= imem_rdata;
      r_mem_pc1[r_wr_ptr] <= w_addr_p1;
    end
  end

  assign imem_req       = (r_state != S_IDLE);
  assign imem_addr      = r_addr;
  assign if_valid       = !w_empty && !redirect_valid;
  assign if_instruction = w_empty ? '0 : r_mem_ins[r_rd_ptr];
  assign if_pc_plus1    = w_empty ? '0 : r_mem_pc1[r_rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (w_push && !w_pop) |-> (r_count < LP_DEPTH));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed test-plan steps followed by a randomized run, scored against an
// in-order fetch-stream model (expected next PC, reset on every redirect).
module tb_if_prefetch_unit;
  logic        clk, rst;
  logic        imem_req, imem_ack;
  logic [11:0] imem_addr;
  logic [18:0] imem_rdata;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [18:0] if_instruction;
  logic [11:0] if_pc_plus1;

  if_prefetch_unit #(.ADDRESS_LEN(12), .INSTRUCTION_LEN(19), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(if_valid),
    .if_instruction(if_instruction), .if_pc_plus1(if_pc_plus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0, bad = 0, npop = 0;
  int          lat_cfg = 0, mem_wait = 0;
  bit          mem_busy = 0, force_ack = 0, rdy = 0, found;
  logic [11:0] req_addr, exp_pc;
  logic [11:0] popped[$];

  function automatic logic [18:0] word(input logic [11:0] a);
    return {a[6:0] ^ 7'h55, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs (memory responder included), score any pop,
  // then return at the following negedge with redirect/ack released.
  task automatic tick(input logic rv, input logic [11:0] rpc);
    logic [11:0] e1;
    redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
    imem_ack = 1'b0; imem_rdata = '0;
    if (force_ack) begin
      imem_ack = 1'b1; imem_rdata = '1; force_ack = 0;
    end else if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_wait = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        req_addr = imem_addr;
      end else begin
        chk("addr_stable", imem_addr, req_addr);
      end
      if (mem_wait == 0) begin
        imem_ack = 1'b1; imem_rdata = word(req_addr); mem_busy = 0;
      end else begin
        mem_wait--;
      end
    end
    #1;
    if (rv) chk("valid_on_redirect", if_valid, 0);
    if (if_valid && id_ready) begin
      e1 = exp_pc + 12'd1;
      chk("pop_pc_plus1", if_pc_plus1, e1);
      chk("pop_instr", if_instruction, word(exp_pc));
      popped.push_back(if_pc_plus1);
      exp_pc = e1;
      npop++;
    end
    if (rv) begin exp_pc = rpc; popped.delete(); end
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
    mem_busy = 0; force_ack = 0; exp_pc = '0; popped.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; id_ready = 1'b0; exp_pc = '0; req_addr = '0;
    #2;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instruction, 0);
    chk("rst_pc1", if_pc_plus1, 0);

    // 1: zero-wait memory, decode always ready
    do_reset(); rdy = 1; lat_cfg = 0;
    tick(0, 0);
    chk("t1_req", imem_req, 1); chk("t1_addr", imem_addr, 0); chk("t1_valid0", if_valid, 0);
    tick(0, 0);
    chk("t1_valid", if_valid, 1); chk("t1_pc1", if_pc_plus1, 12'h001);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0);
      chk("t1_stream_valid", if_valid, 1);
      chk("t1_stream_pc1", if_pc_plus1, i + 2);
    end

    // 2: decode stalls, FIFO fills to DEPTH, then drains in order
    do_reset(); rdy = 0; lat_cfg = 0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0);
      if (i >= 4) chk("t2_req_full", imem_req, 0);
    end
    chk("t2_valid", if_valid, 1); chk("t2_head", if_pc_plus1, 12'h001);
    rdy = 1; lat_cfg = 8;
    tick(0, 0); chk("t2_noissue", imem_req, 0); chk("t2_h2", if_pc_plus1, 12'h002);
    tick(0, 0); chk("t2_resume_req", imem_req, 1); chk("t2_resume_addr", imem_addr, 12'h004);
    chk("t2_h3", if_pc_plus1, 12'h003);
    tick(0, 0); chk("t2_h4", if_pc_plus1, 12'h004);
    tick(0, 0); chk("t2_empty", if_valid, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(0, 0);
      if (if_valid) found = 1;
    end
    chk("t2_refill_seen", found, 1);
    chk("t2_refill_pc1", if_pc_plus1, 12'h005);

    // 3: redirect while a slow fetch is outstanding
    do_reset(); rdy = 1; lat_cfg = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(0, 0);
      if (imem_req && imem_addr == 12'h005) found = 1;
    end
    chk("t3_issue5_seen", found, 1);
    lat_cfg = 3;
    tick(0, 0);        chk("t3_addr_a", imem_addr, 12'h005);
    tick(1, 12'h0A0);  chk("t3_addr_b", imem_addr, 12'h005); chk("t3_req_b", imem_req, 1);
    chk("t3_flushed", if_valid, 0);
    tick(0, 0);        chk("t3_addr_c", imem_addr, 12'h005); chk("t3_req_c", imem_req, 1);
    tick(0, 0);        chk("t3_idle", imem_req, 0); chk("t3_nopush", if_valid, 0);
    lat_cfg = 0;
    tick(0, 0);        chk("t3_new_req", imem_req, 1); chk("t3_new_addr", imem_addr, 12'h0A0);
    tick(0, 0);        chk("t3_valid", if_valid, 1); chk("t3_pc1", if_pc_plus1, 12'h0A1);

    // 4: redirect coincides with an ack while two entries are buffered
    do_reset(); rdy = 0; lat_cfg = 0;
    tick(0, 0); tick(0, 0); tick(0, 0);
    chk("t4_head", if_pc_plus1, 12'h001); chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 12'h002);
    tick(1, 12'h300);
    chk("t4_valid_after", if_valid, 0); chk("t4_req_idle", imem_req, 0);
    rdy = 1;
    tick(0, 0);        chk("t4_new_addr", imem_addr, 12'h300); chk("t4_new_req", imem_req, 1);
    tick(0, 0);        chk("t4_pc1", if_pc_plus1, 12'h301);

    // 5: redirect near the top of the address space wraps cleanly
    tick(1, 12'hFFE);
    for (int i = 0; i < 8; i++) tick(0, 0);
    chk("t5_count", popped.size() >= 3, 1);
    if (popped.size() >= 3) begin
      chk("t5_p0", popped[0], 12'hFFF);
      chk("t5_p1", popped[1], 12'h000);
      chk("t5_p2", popped[2], 12'h001);
    end

    // 6: asynchronous reset with a request outstanding and 3 entries held
    do_reset(); rdy = 0; lat_cfg = 0;
    tick(0, 0); tick(0, 0); tick(0, 0); tick(0, 0);
    lat_cfg = 10;
    tick(0, 0);
    chk("t6_pre_req", imem_req, 1); chk("t6_pre_head", if_pc_plus1, 12'h001);
    #2; rst = 1'b0; #1;
    chk("t6_req", imem_req, 0); chk("t6_addr", imem_addr, 0); chk("t6_valid", if_valid, 0);
    chk("t6_instr", if_instruction, 0); chk("t6_pc1", if_pc_plus1, 0);
    mem_busy = 0; exp_pc = '0; popped.delete();
    @(negedge clk); rst = 1'b1;
    rdy = 1; lat_cfg = 0; force_ack = 1;
    tick(0, 0);
    chk("t6_stray_ignored", if_valid, 0); chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 0);
    tick(0, 0);
    chk("t6_first_pc1", if_pc_plus1, 12'h001); chk("t6_first_ins", if_instruction, word(12'h000));

    // Randomized traffic: latencies, stalls and redirects
    do_reset(); lat_cfg = -1; npop = 0;
    for (int i = 0; i < 1500; i++) begin
      logic        rv;
      logic [11:0] rpc;
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3)) : 12'($urandom);
      tick(rv, rpc);
    end
    chk("rand_progress", npop > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
